// File: rtl/host_rd_pkg.sv
// Shared types and helpers for the host DDR readout engine.
package host_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] CMD_READ = 3'b001;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned bytes_per_word(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned log2_bpw(input int unsigned dw);
        return $clog2(bytes_per_word(dw));
    endfunction

endpackage

// File: rtl/host_rd_addr_gen.sv
// Command address register and burst length selection for the readout engine.
// With HOST_RD_STRIDE_EN defined, bursts stop at line ends and lines advance by a stride.
module host_rd_addr_gen
    import host_rd_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int WL_W        = 21,
    parameter int BURST_WORDS = 32,
    parameter int LOG2_BPW    = 3
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [WL_W-1:0]   words_left,
`ifdef HOST_RD_STRIDE_EN
    input  logic [15:0]       line_words,
    input  logic [ADDR_W-1:0] line_stride,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [6:0]        blen
);

    logic [ADDR_W-1:0] step;
    assign step = ADDR_W'(blen) << LOG2_BPW;

`ifdef HOST_RD_STRIDE_EN
    logic [15:0]       lw_q;
    logic [15:0]       line_rem;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_start;
    int unsigned       lim;

    // A zero line length means plain linear addressing.
    always_comb begin
        // NOTE: lim gets a default before any condition so no path leaves it unassigned (no latch).
        lim = min_u(BURST_WORDS, 32'(words_left));
        if (lw_q != '0) begin
            lim = min_u(lim, 32'(line_rem));
        end
        blen = 7'(lim);
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            addr       <= '0;
            line_start <= '0;
            lw_q       <= '0;
            stride_q   <= '0;
            line_rem   <= '0;
        end else if (load) begin
            addr       <= start_addr;
            line_start <= start_addr;
            lw_q       <= line_words;
            stride_q   <= line_stride;
            line_rem   <= line_words;
        end else if (advance) begin
            if ((lw_q != '0) && (16'(blen) == line_rem)) begin
                line_start <= line_start + stride_q;
                addr       <= line_start + stride_q;
                line_rem   <= lw_q;
            end else begin
                addr     <= addr + step;
                line_rem <= line_rem - 16'(blen);
            end
        end
    end
`else
    always_comb begin
        blen = 7'(min_u(BURST_WORDS, 32'(words_left)));
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            addr <= '0;
        end else if (load) begin
            addr <= start_addr;
        end else if (advance) begin
            addr <= addr + step;
        end
    end
`endif

endmodule

// File: rtl/host_rd_engine.sv
// DDR readout engine: streams a byte-counted region from the read port into the pipe-out FIFO.
// Optional 2D window readout is enabled by defining HOST_RD_STRIDE_EN.
module host_rd_engine
    import host_rd_pkg::*;
#(
    parameter int MEM_DW      = 64,
    parameter int ADDR_W      = 30,
    parameter int COUNT_W     = 24,
    parameter int BURST_WORDS = 32,
    parameter int OB_COUNT_W  = 10,
    parameter int OB_THRESH   = 440
) (
    input  logic                  clk,
    input  logic                  reset_clk,
    input  logic                  readout_start,
    input  logic                  readout_abort,
    input  logic [ADDR_W-1:0]     readout_addr,
    input  logic [COUNT_W-1:0]    readout_count,
`ifdef HOST_RD_STRIDE_EN
    input  logic [15:0]           line_words,
    input  logic [ADDR_W-1:0]     line_stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_cmd_en,
    output logic [2:0]            mem_cmd_instr,
    output logic [ADDR_W-1:0]     mem_cmd_byte_addr,
    output logic [5:0]            mem_cmd_burst_len,
    input  logic                  mem_cmd_full,
    output logic                  mem_rd_en,
    input  logic [MEM_DW-1:0]     mem_rd_data,
    input  logic                  mem_rd_empty,
    output logic                  ob_rst,
    output logic                  ob_wr_en,
    output logic [MEM_DW-1:0]     ob_din,
    input  logic [OB_COUNT_W-1:0] ob_wr_count
);

    localparam int LOG2_BPW = log2_bpw(MEM_DW);
    localparam int WL_W     = COUNT_W - LOG2_BPW;
    localparam logic [OB_COUNT_W:0] OB_LIMIT = (OB_COUNT_W + 1)'(OB_THRESH);

    state_t            state;
    logic [WL_W-1:0]   words_left;
    logic [6:0]        burst_cnt;
    logic [6:0]        blen;
    logic [ADDR_W-1:0] addr;
    logic              pop;
    logic              load;
    logic              fire;

    assign mem_cmd_instr = CMD_READ;
    assign pop  = mem_rd_en & ~mem_rd_empty;
    assign load = (state == IDLE) && readout_start;
    assign fire = (state == ISSUE) && (words_left != '0) && !mem_cmd_full
                  && ({1'b0, ob_wr_count} < OB_LIMIT);

    host_rd_addr_gen #(
        .ADDR_W      (ADDR_W),
        .WL_W        (WL_W),
        .BURST_WORDS (BURST_WORDS),
        .LOG2_BPW    (LOG2_BPW)
    ) u_addr_gen (
        .clk        (clk),
        .reset_clk  (reset_clk),
        .load       (load),
        .advance    (fire),
        .start_addr (readout_addr),
        .words_left (words_left),
`ifdef HOST_RD_STRIDE_EN
        .line_words (line_words),
        .line_stride(line_stride),
`endif
        .addr       (addr),
        .blen       (blen)
    );

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            ob_wr_en <= 1'b0;
            ob_din   <= '0;
        end else begin
            ob_wr_en <= pop && (state == DRAIN);
            ob_din   <= mem_rd_data;
        end
    end

    // NOTE: every register here uses <= so all branches see pre-edge values of state and counters.
    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            ob_rst            <= 1'b1;
            mem_rd_en         <= 1'b0;
            mem_cmd_en        <= 1'b0;
            mem_cmd_byte_addr <= '0;
            mem_cmd_burst_len <= '0;
            words_left        <= '0;
            burst_cnt         <= '0;
        end else begin
            mem_rd_en  <= 1'b1;
            done       <= 1'b0;
            ob_rst     <= 1'b0;
            mem_cmd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (readout_start) begin
                        busy       <= 1'b1;
                        ob_rst     <= 1'b1;
                        words_left <= WL_W'(readout_count >> LOG2_BPW);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A command strobed alongside an abort is still owed its data.
                    if (fire) begin
                        mem_cmd_en        <= 1'b1;
                        mem_cmd_byte_addr <= addr;
                        mem_cmd_burst_len <= 6'(blen - 7'd1);
                        burst_cnt         <= blen;
                        state             <= readout_abort ? FLUSH : DRAIN;
                    end else if (readout_abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (words_left == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        burst_cnt  <= burst_cnt - 7'd1;
                        words_left <= words_left - 1'b1;
                    end
                    if (readout_abort) begin
                        if (pop && (burst_cnt == 7'd1)) begin
                            ob_rst <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (pop && (burst_cnt == 7'd1)) begin
                        if (words_left == WL_W'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                FLUSH: begin
                    if (pop && (burst_cnt != '0)) begin
                        burst_cnt <= burst_cnt - 7'd1;
                    end
                    if ((burst_cnt == '0) || (pop && (burst_cnt == 7'd1))) begin
                        ob_rst <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_rd_engine.sv
// Scoreboard bench for host_rd_engine with a small DDR read-port model.
// The window readout case runs only when HOST_RD_STRIDE_EN is defined.
`timescale 1ns/1ps
module tb_host_rd_engine;

    localparam int ADDR_W     = 30;
    localparam int COUNT_W    = 24;
    localparam int OB_COUNT_W = 10;

    logic                  clk = 1'b0;
    logic                  reset_clk = 1'b1;
    logic                  readout_start = 1'b0;
    logic                  readout_abort = 1'b0;
    logic [ADDR_W-1:0]     readout_addr = '0;
    logic [COUNT_W-1:0]    readout_count = '0;
`ifdef HOST_RD_STRIDE_EN
    logic [15:0]           line_words = '0;
    logic [ADDR_W-1:0]     line_stride = '0;
`endif
    logic                  busy, done, mem_cmd_en, mem_rd_en, ob_rst, ob_wr_en;
    logic [2:0]            mem_cmd_instr;
    logic [ADDR_W-1:0]     mem_cmd_byte_addr;
    logic [5:0]            mem_cmd_burst_len;
    logic                  mem_cmd_full = 1'b0;
    logic [63:0]           mem_rd_data;
    logic                  mem_rd_empty;
    logic [63:0]           ob_din;
    logic [OB_COUNT_W-1:0] ob_wr_count = '0;

    always #5 clk = ~clk;

    host_rd_engine dut (
        .clk              (clk),
        .reset_clk        (reset_clk),
        .readout_start    (readout_start),
        .readout_abort    (readout_abort),
        .readout_addr     (readout_addr),
        .readout_count    (readout_count),
`ifdef HOST_RD_STRIDE_EN
        .line_words       (line_words),
        .line_stride      (line_stride),
`endif
        .busy             (busy),
        .done             (done),
        .mem_cmd_en       (mem_cmd_en),
        .mem_cmd_instr    (mem_cmd_instr),
        .mem_cmd_byte_addr(mem_cmd_byte_addr),
        .mem_cmd_burst_len(mem_cmd_burst_len),
        .mem_cmd_full     (mem_cmd_full),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_empty     (mem_rd_empty),
        .ob_rst           (ob_rst),
        .ob_wr_en         (ob_wr_en),
        .ob_din           (ob_din),
        .ob_wr_count      (ob_wr_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [5:0]        len;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [63:0] exp_wr_q[$];
    cmd_t        mon_c;
    logic [63:0] mon_w;
    int          exp_done = 0;
    int          exp_rst = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          cmd_seen = 0;
    bit          mon_en = 1'b0;

    logic [63:0] ddr_q[$];
    int          ddr_limit = -1;
    int          ddr_supplied = 0;
    int          ddr_cyc = 0;

    function automatic logic [63:0] word_data(input logic [ADDR_W-1:0] a);
        return {~{2'b00, a}, {2'b00, a}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DDR read port: words queue up behind each command and drain with a periodic empty gap.
    initial begin
        mem_rd_empty = 1'b1;
        mem_rd_data  = '0;
        forever begin
            @(posedge clk);
            if (!mem_rd_empty && mem_rd_en) begin
                void'(ddr_q.pop_front());
                ddr_supplied++;
            end
            #1;
            ddr_cyc++;
            if (ddr_q.size() != 0 && (ddr_cyc % 5) != 4 && (ddr_limit < 0 || ddr_supplied < ddr_limit)) begin
                mem_rd_empty = 1'b0;
                mem_rd_data  = ddr_q[0];
            end else begin
                mem_rd_empty = 1'b1;
                mem_rd_data  = {$urandom, $urandom};
            end
        end
    end

    always @(negedge clk) begin
        if (mem_cmd_en) begin
            for (int i = 0; i <= int'(mem_cmd_burst_len); i++) begin
                ddr_q.push_back(word_data(mem_cmd_byte_addr + ADDR_W'(i * 8)));
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_cmd_en) begin
                cmd_seen++;
                check("cmd_expected", 64'(exp_cmd_q.size() > 0), 64'd1);
                if (exp_cmd_q.size() > 0) begin
                    mon_c = exp_cmd_q.pop_front();
                    check("cmd_addr", 64'(mem_cmd_byte_addr), 64'(mon_c.addr));
                    check("cmd_len", 64'(mem_cmd_burst_len), 64'(mon_c.len));
                    check("cmd_instr", 64'(mem_cmd_instr), 64'd1);
                end
            end
            if (ob_wr_en) begin
                wr_seen++;
                check("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0) begin
                    mon_w = exp_wr_q.pop_front();
                    check("wr_data", ob_din, mon_w);
                end
            end
            if (done) begin
                check("done_expected", 64'(exp_done > 0), 64'd1);
                if (exp_done > 0) exp_done--;
                check("done_busy_low", 64'(busy), 64'd0);
            end
            if (ob_rst) begin
                check("ob_rst_expected", 64'(exp_rst > 0), 64'd1);
                if (exp_rst > 0) exp_rst--;
            end
        end
    end

    task automatic expect_cmd(input logic [ADDR_W-1:0] a, input logic [5:0] len);
        cmd_t c;
        c.addr = a;
        c.len  = len;
        exp_cmd_q.push_back(c);
    endtask

    task automatic push_words(input logic [ADDR_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_wr_q.push_back(word_data(base + ADDR_W'(i * 8)));
    endtask

    task automatic start_rd(input logic [ADDR_W-1:0] a, input logic [COUNT_W-1:0] c);
        @(posedge clk);
        #1;
        readout_addr  = a;
        readout_count = c;
        readout_start = 1'b1;
        @(posedge clk);
        #1;
        readout_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check(name, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_writes(input string name, input int n);
        for (int i = 0; i < 3000 && wr_seen < n; i++) @(negedge clk);
        check(name, 64'(wr_seen >= n), 64'd1);
    endtask

    task automatic end_test(input string name);
        check({name, "_cmds_left"}, 64'(exp_cmd_q.size()), 64'd0);
        check({name, "_words_left"}, 64'(exp_wr_q.size()), 64'd0);
        check({name, "_done_left"}, 64'(exp_done), 64'd0);
        check({name, "_rst_left"}, 64'(exp_rst), 64'd0);
        wr_seen  = 0;
        cmd_seen = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #22;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cmd_en", 64'(mem_cmd_en), 64'd0);
        check("rst_instr", 64'(mem_cmd_instr), 64'd1);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_ob_rst", 64'(ob_rst), 64'd1);
        check("rst_wr_en", 64'(ob_wr_en), 64'd0);
        check("rst_din", ob_din, 64'd0);
        @(posedge clk);
        #2 reset_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ob_rst", 64'(ob_rst), 64'd0);
        check("post_rst_rd_en", 64'(mem_rd_en), 64'd1);
        mon_en = 1'b1;

        // Two full bursts
        exp_rst++;
        expect_cmd(30'h1000, 6'd31);
        expect_cmd(30'h1100, 6'd31);
        push_words(30'h1000, 64);
        exp_done++;
        start_rd(30'h1000, 24'd512);
        wait_idle("t1_idle");
        check("t1_writes", 64'(wr_seen), 64'd64);
        end_test("t1");

        // Short final burst
        exp_rst++;
        expect_cmd(30'h0800, 6'd24);
        push_words(30'h0800, 25);
        exp_done++;
        start_rd(30'h0800, 24'd200);
        wait_idle("t2_idle");
        check("t2_writes", 64'(wr_seen), 64'd25);
        end_test("t2");

        // FIFO threshold and command-full stalls
        ob_wr_count = 10'd440;
        exp_rst++;
        expect_cmd(30'h4000, 6'd31);
        expect_cmd(30'h4100, 6'd31);
        push_words(30'h4000, 64);
        exp_done++;
        start_rd(30'h4000, 24'd512);
        repeat (10) @(negedge clk);
        check("t3_thresh_no_cmd", 64'(cmd_seen), 64'd0);
        @(posedge clk);
        #1 ob_wr_count = 10'd439;
        @(negedge clk);
        check("t3_thresh_not_yet", 64'(mem_cmd_en), 64'd0);
        @(negedge clk);
        check("t3_thresh_cmd_next", 64'(mem_cmd_en), 64'd1);
        mem_cmd_full = 1'b1;
        wait_writes("t3_first_burst", 32);
        repeat (8) @(negedge clk);
        check("t3_full_no_cmd", 64'(cmd_seen), 64'd1);
        @(posedge clk);
        #1 mem_cmd_full = 1'b0;
        @(negedge clk);
        check("t3_full_not_yet", 64'(mem_cmd_en), 64'd0);
        @(negedge clk);
        check("t3_full_cmd_next", 64'(mem_cmd_en), 64'd1);
        ob_wr_count = '0;
        wait_idle("t3_idle");
        end_test("t3");

        // Abort after 10 of 32 words, then a normal readout
        ddr_supplied = 0;
        ddr_limit    = 10;
        exp_rst      = exp_rst + 2;
        expect_cmd(30'h1000, 6'd31);
        push_words(30'h1000, 10);
        start_rd(30'h1000, 24'd512);
        wait_writes("t4_ten_words", 10);
        @(posedge clk);
        #1 readout_abort = 1'b1;
        @(posedge clk);
        #1;
        readout_abort = 1'b0;
        ddr_limit     = -1;
        wait_idle("t4_idle");
        check("t4_writes", 64'(wr_seen), 64'd10);
        check("t4_popped", 64'(ddr_supplied), 64'd32);
        check("t4_drained", 64'(ddr_q.size()), 64'd0);
        end_test("t4");
        exp_rst++;
        expect_cmd(30'h2000, 6'd31);
        push_words(30'h2000, 32);
        exp_done++;
        start_rd(30'h2000, 24'd256);
        wait_idle("t4b_idle");
        end_test("t4b");

        // Zero count
        exp_rst++;
        exp_done++;
        start_rd(30'h5000, 24'd0);
        @(negedge clk);
        check("t5_busy_first", 64'(busy), 64'd1);
        check("t5_done_first", 64'(done), 64'd0);
        @(negedge clk);
        check("t5_done_second", 64'(done), 64'd1);
        wait_idle("t5_idle");
        check("t5_no_cmd", 64'(cmd_seen), 64'd0);
        end_test("t5");

        // Address wrap across the top of the address space
        exp_rst++;
        expect_cmd(30'h3FFF_FF00, 6'd31);
        expect_cmd(30'h0000_0000, 6'd31);
        push_words(30'h3FFF_FF00, 64);
        exp_done++;
        start_rd(30'h3FFF_FF00, 24'd512);
        wait_idle("t7_idle");
        end_test("t7");

`ifdef HOST_RD_STRIDE_EN
        // Window readout with line-bounded bursts
        line_words  = 16'd40;
        line_stride = 30'h400;
        exp_rst++;
        expect_cmd(30'h000, 6'd31);
        expect_cmd(30'h100, 6'd7);
        expect_cmd(30'h400, 6'd31);
        expect_cmd(30'h500, 6'd7);
        push_words(30'h000, 32);
        push_words(30'h100, 8);
        push_words(30'h400, 32);
        push_words(30'h500, 8);
        exp_done++;
        start_rd(30'h0, 24'd640);
        wait_idle("t6_idle");
        check("t6_writes", 64'(wr_seen), 64'd80);
        end_test("t6");
        line_words  = '0;
        line_stride = '0;
`endif

        // Reset in the middle of a readout
        exp_rst++;
        expect_cmd(30'h6000, 6'd31);
        push_words(30'h6000, 32);
        start_rd(30'h6000, 24'd512);
        wait_writes("t8_some_words", 5);
        @(posedge clk);
        #3;
        mon_en    = 1'b0;
        reset_clk = 1'b1;
        ddr_q.delete();
        mem_rd_empty = 1'b1;
        #1;
        check("t8_rst_ob_rst", 64'(ob_rst), 64'd1);
        check("t8_rst_busy", 64'(busy), 64'd0);
        check("t8_rst_wr_en", 64'(ob_wr_en), 64'd0);
        exp_cmd_q.delete();
        exp_wr_q.delete();
        exp_done = 0;
        exp_rst  = 0;
        wr_seen  = 0;
        cmd_seen = 0;
        @(posedge clk);
        #3 reset_clk = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        exp_rst++;
        expect_cmd(30'h7000, 6'd7);
        push_words(30'h7000, 8);
        exp_done++;
        start_rd(30'h7000, 24'd64);
        wait_idle("t8_idle");
        end_test("t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
